axi_wr_rr_arbiter: RTL and testbench



---
 rtl/axi_wr_rr_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_axi_wr_rr_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin arbiter that shares one AXI4 write path (AW, W, B) among NUM_M
// masters. Only one write transaction is in flight at a time: the address,
// then the full data burst, then the response. Every channel is a
// combinational pass-through from the granted master. The only registered
// state is the phase FSM, the one-hot grant and the index of the last master
// to complete.

// Per-master gating of the outputs that face each master. An ungranted lane,
// or a lane whose phase is not active, reads 0.
module axi_wr_rr_lane (
  input  logic gnt,
  input  logic aw_phase,
  input  logic w_phase,
  input  logic b_phase,
  input  logic m_awready,
  input  logic m_wready,
  input  logic m_bvalid,
  output logic s_awready,
  output logic s_wready,
  output logic s_bvalid
);
  assign s_awready = gnt & aw_phase & m_awready;
  assign s_wready  = gnt & w_phase  & m_wready;
  assign s_bvalid  = gnt & b_phase  & m_bvalid;
endmodule

module axi_wr_rr_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  // upstream AW
  input  logic [NUM_M-1:0]           s_awvalid,
  output logic [NUM_M-1:0]           s_awready,
  input  logic [NUM_M*ADDR_W-1:0]    s_awaddr,
  input  logic [NUM_M*8-1:0]         s_awlen,
  input  logic [NUM_M*ID_W-1:0]      s_awid,
  // upstream W
  input  logic [NUM_M-1:0]           s_wvalid,
  output logic [NUM_M-1:0]           s_wready,
  input  logic [NUM_M*DATA_W-1:0]    s_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]  s_wstrb,
  input  logic [NUM_M-1:0]           s_wlast,
  // upstream B
  output logic [NUM_M-1:0]           s_bvalid,
  input  logic [NUM_M-1:0]           s_bready,
  output logic [1:0]                 s_bresp,
  output logic [ID_W-1:0]            s_bid,
  // downstream AW
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic [7:0]                 m_awlen,
  output logic [ID_W-1:0]            m_awid,
  // downstream W
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_wlast,
  // downstream B
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp,
  input  logic [ID_W-1:0]            m_bid,
  // current owner of the path, one-hot, zero while idle
  output logic [NUM_M-1:0]           grant
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_M);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q,  last_d;

  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               pick_vld;
  logic               aw_phase, w_phase, b_phase;

  // Per-master views of the flattened payload buses. Slice i belongs to master i.
  logic [NUM_M-1:0][ADDR_W-1:0] awaddr_v;
  logic [NUM_M-1:0][7:0]        awlen_v;
  logic [NUM_M-1:0][ID_W-1:0]   awid_v;
  logic [NUM_M-1:0][DATA_W-1:0] wdata_v;
  logic [NUM_M-1:0][STRB_W-1:0] wstrb_v;

  assign awaddr_v = s_awaddr;
  assign awlen_v  = s_awlen;
  assign awid_v   = s_awid;
  assign wdata_v  = s_wdata;
  assign wstrb_v  = s_wstrb;

  assign aw_phase = (state_q == S_ADDR);
  assign w_phase  = (state_q == S_DATA);
  assign b_phase  = (state_q == S_RESP);

  // Scan from last+1 with wrap. The first requester found wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_M);
      if (!pick_vld && s_awvalid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Convert the one-hot grant to an index that drives the payload muxes.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q[i]) gidx = IDX_W'(i);
    end
  end

  // Downstream muxes. Each valid is gated by its phase. Each payload is a
  // straight mux output and is meaningful only while its valid is high.
  assign m_awvalid = aw_phase & s_awvalid[gidx];
  assign m_awaddr  = awaddr_v[gidx];
  assign m_awlen   = awlen_v[gidx];
  assign m_awid    = awid_v[gidx];

  assign m_wvalid  = w_phase & s_wvalid[gidx];
  assign m_wdata   = wdata_v[gidx];
  assign m_wstrb   = wstrb_v[gidx];
  assign m_wlast   = s_wlast[gidx];

  assign m_bready  = b_phase & s_bready[gidx];
  assign s_bresp   = m_bresp;
  assign s_bid     = m_bid;

  assign grant     = grant_q;

  // Upstream ready/valid gating. There is one lane instance per master.
  for (genvar i = 0; i < NUM_M; i++) begin : g_lane
    axi_wr_rr_lane u_lane (
      .gnt       (grant_q[i]),
      .aw_phase  (aw_phase),
      .w_phase   (w_phase),
      .b_phase   (b_phase),
      .m_awready (m_awready),
      .m_wready  (m_wready),
      .m_bvalid  (m_bvalid),
      .s_awready (s_awready[i]),
      .s_wready  (s_wready[i]),
      .s_bvalid  (s_bvalid[i])
    );
  end

  // Phase sequencing: IDLE -> ADDR -> DATA -> RESP -> IDLE.
  // The grant is held until the B handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_awvalid && m_awready) state_d = S_DATA;
      end
      S_DATA: begin
        if (m_wvalid && m_wready && m_wlast) state_d = S_RESP;
      end
      S_RESP: begin
        if (m_bvalid && m_bready) begin
          last_d  = gidx;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers. Reset makes master 0 the first winner and drops any
  // transaction that is in flight.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Directed bench for axi_wr_rr_arbiter. A transaction-level model (owner index,
// phase, last winner) predicts every ready/valid output and every payload
// pass-through on each negedge. Directed tests add literal checks on beat
// order, grant order, turnaround gap and response routing.
module tb_axi_wr_rr_arbiter;
  localparam int NM = 2, AW = 32, DW = 32, IW = 4, SW = DW / 8;
  localparam int P_IDLE = 0, P_ADDR = 1, P_DATA = 2, P_RESP = 3;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    s_awvalid = '0, s_awready;
  logic [NM*AW-1:0] s_awaddr = '0;
  logic [NM*8-1:0]  s_awlen = '0;
  logic [NM*IW-1:0] s_awid = '0;
  logic [NM-1:0]    s_wvalid = '0, s_wready;
  logic [NM*DW-1:0] s_wdata = '0;
  logic [NM*SW-1:0] s_wstrb = '0;
  logic [NM-1:0]    s_wlast = '0;
  logic [NM-1:0]    s_bvalid, s_bready = '0;
  logic [1:0]       s_bresp;
  logic [IW-1:0]    s_bid;
  logic             m_awvalid, m_awready = 1'b1;
  logic [AW-1:0]    m_awaddr;
  logic [7:0]       m_awlen;
  logic [IW-1:0]    m_awid;
  logic             m_wvalid, m_wready = 1'b1;
  logic [DW-1:0]    m_wdata;
  logic [SW-1:0]    m_wstrb;
  logic             m_wlast;
  logic             m_bvalid = 1'b0, m_bready;
  logic [1:0]       m_bresp = '0;
  logic [IW-1:0]    m_bid = '0;
  logic [NM-1:0]    grant;

  axi_wr_rr_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .aclk(clk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .grant(grant)
  );

  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  // Records of completed handshakes, used by the directed checks.
  logic [DW-1:0] wq[$];
  logic          lq[$];
  logic [NM-1:0] wgq[$];
  int            aw_own[$], aw_start[$], b_cyc[$];
  logic [NM-1:0] bv_q[$];
  logic [1:0]    br_q[$];
  logic [IW-1:0] bid_q[$];
  logic [1:0]    bresp_cfg = '0;
  logic [IW-1:0] bid_cfg = '0;

  task automatic clear_q();
    wq.delete(); lq.delete(); wgq.delete(); aw_own.delete(); aw_start.delete();
    b_cyc.delete(); bv_q.delete(); br_q.delete(); bid_q.delete();
  endtask

  // Model: owner mo (-1 = none), phase mp, last winner ml.
  int   mo = -1, mp = P_IDLE, ml = NM - 1;
  bit   mon = 0;
  logic prev_awv = 1'b0;
  always @(negedge clk) begin
    logic [NM-1:0] eg;
    int gi;
    eg = '0;
    if (mo >= 0) eg[mo] = 1'b1;
    if (mon) begin
      chk("grant", grant, eg);
      chk("m_awvalid", m_awvalid, (mp == P_ADDR) && (mo >= 0) && s_awvalid[mo]);
      chk("s_awready", s_awready, (mp == P_ADDR && m_awready) ? eg : '0);
      chk("m_wvalid", m_wvalid, (mp == P_DATA) && (mo >= 0) && s_wvalid[mo]);
      chk("s_wready", s_wready, (mp == P_DATA && m_wready) ? eg : '0);
      chk("m_bready", m_bready, (mp == P_RESP) && (mo >= 0) && s_bready[mo]);
      chk("s_bvalid", s_bvalid, (mp == P_RESP && m_bvalid) ? eg : '0);
      if (m_awvalid && mo >= 0) begin
        chk("m_awaddr", m_awaddr, s_awaddr[mo*AW +: AW]);
        chk("m_awlen", m_awlen, s_awlen[mo*8 +: 8]);
        chk("m_awid", m_awid, s_awid[mo*IW +: IW]);
      end
      if (m_wvalid && mo >= 0) begin
        chk("m_wdata", m_wdata, s_wdata[mo*DW +: DW]);
        chk("m_wstrb", m_wstrb, s_wstrb[mo*SW +: SW]);
        chk("m_wlast", m_wlast, s_wlast[mo]);
      end
      if (|s_bvalid) begin
        chk("s_bresp", s_bresp, m_bresp);
        chk("s_bid", s_bid, m_bid);
      end
    end
    gi = -1;
    for (int i = 0; i < NM; i++) if (grant[i]) gi = i;
    if (m_awvalid && !prev_awv) aw_start.push_back(cyc);
    prev_awv = m_awvalid;
    if (m_awvalid && m_awready) aw_own.push_back(gi);
    if (m_wvalid && m_wready) begin
      wq.push_back(m_wdata); lq.push_back(m_wlast); wgq.push_back(grant);
    end
    if (m_bvalid && m_bready) begin
      b_cyc.push_back(cyc); bv_q.push_back(s_bvalid);
      br_q.push_back(s_bresp); bid_q.push_back(s_bid);
    end
    // Compute the model state that takes effect at the next edge.
    if (!aresetn) begin
      mo = -1; mp = P_IDLE; ml = NM - 1; mon = 1;
    end else if (mon) begin
      case (mp)
        P_IDLE: if (|s_awvalid) begin
          for (int k = 1; k <= NM; k++)
            if (s_awvalid[(ml + k) % NM]) begin mo = (ml + k) % NM; break; end
          mp = P_ADDR;
        end
        P_ADDR: if (s_awvalid[mo] && m_awready) mp = P_DATA;
        P_DATA: if (s_wvalid[mo] && m_wready && s_wlast[mo]) mp = P_RESP;
        P_RESP: if (m_bvalid && s_bready[mo]) begin ml = mo; mo = -1; mp = P_IDLE; end
        default: mp = P_IDLE;
      endcase
    end
  end

  // Slave B side: return a response in the cycle after the last W beat.
  bit s_whs, s_bhs, s_rst;
  always begin
    @(negedge clk);
    s_whs = m_wvalid && m_wready && m_wlast;
    s_bhs = m_bvalid && m_bready;
    s_rst = !aresetn;
    @(posedge clk); #1;
    if (s_rst || s_bhs) m_bvalid = 1'b0;
    else if (s_whs) begin m_bvalid = 1'b1; m_bresp = bresp_cfg; m_bid = bid_cfg; end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Wait for handshake ch (0 = AW, 1 = W, 2 = B) on master m. Returns at
  // posedge+1 after the handshake, or with ab set on reset or timeout.
  task automatic wait_hs(input int m, input int ch, input string nm, output bit ab);
    bit hit;
    int n;
    n = 0; ab = 0;
    forever begin
      @(negedge clk);
      hit = (ch == 0) ? s_awready[m] : (ch == 1) ? s_wready[m] : s_bvalid[m];
      if (!aresetn) begin ab = 1; break; end
      if (hit) break;
      n++;
      if (n >= 300) begin
        vectors++; miscompares++;
        $display("FAIL timeout_%s: no handshake in 300 cycles, expected one", nm);
        ab = 1; break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic mwrite(input int m, input logic [31:0] addr, input int len,
                        input logic [31:0] dbase, input logic [3:0] id, input int lead);
    bit ab;
    logic [7:0] l8;
    l8 = len[7:0];
    ab = 0;
    s_awaddr[m*AW +: AW] = addr;
    s_awlen[m*8 +: 8]    = l8;
    s_awid[m*IW +: IW]   = id;
    s_wstrb[m*SW +: SW]  = '1;
    s_wdata[m*DW +: DW]  = dbase;
    s_wlast[m]           = (len == 0);
    if (lead > 0) begin
      s_wvalid[m] = 1'b1;
      repeat (lead) begin
        @(negedge clk);
        chk("early_s_wready", s_wready[m], 0);
        chk("early_m_wvalid", m_wvalid, 0);
        step();
      end
    end
    s_awvalid[m] = 1'b1;
    wait_hs(m, 0, "aw", ab);
    s_awvalid[m] = 1'b0;
    if (!ab) begin
      s_wvalid[m] = 1'b1;
      for (int b = 0; b <= len && !ab; b++) begin
        s_wdata[m*DW +: DW] = dbase + 32'(b);
        s_wlast[m]          = (b == len);
        wait_hs(m, 1, "w", ab);
      end
    end
    s_wvalid[m] = 1'b0; s_wlast[m] = 1'b0;
    if (!ab) begin
      s_bready[m] = 1'b1;
      wait_hs(m, 2, "b", ab);
    end
    s_awvalid[m] = 1'b0; s_wvalid[m] = 1'b0; s_bready[m] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    repeat (3) step();
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_s_ready", {s_awready, s_wready, s_bvalid}, 0);
    step();

    // Contention: both masters request continuously, 4 single-beat writes each.
    clear_q();
    fork
      for (int i = 0; i < 4; i++) mwrite(0, 32'h1000 + 32'(i * 16), 0, 32'hC0 + 32'(i), 4'h1, 0);
      for (int j = 0; j < 4; j++) mwrite(1, 32'h2000 + 32'(j * 16), 0, 32'hD0 + 32'(j), 4'h2, 0);
    join
    chk("cont_count", aw_own.size(), 8);
    for (int i = 0; i < 8 && i < aw_own.size(); i++) chk("cont_order", aw_own[i], i % 2);
    for (int i = 1; i < 8 && i < aw_start.size() && i <= b_cyc.size(); i++)
      chk("cont_gap", aw_start[i] - b_cyc[i-1], 2);
    repeat (2) step();

    // Single master 1, 4-beat burst.
    clear_q();
    mwrite(1, 32'h100, 3, 32'hA0, 4'h3, 0);
    chk("single_beats", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      chk("single_wdata", wq[i], 32'hA0 + 32'(i));
      chk("single_wlast", lq[i], (i == 3));
      chk("single_grant", wgq[i], 2'b10);
    end
    chk("single_bcount", bv_q.size(), 1);
    if (bv_q.size() > 0) begin
      chk("single_bvalid", bv_q[0], 2'b10);
      chk("single_bresp", br_q[0], 2'b00);
    end
    @(negedge clk);
    chk("single_grant_after", grant, 0);
    step();

    // Back-pressure: AW stalled for 5 cycles, then W ready alternates.
    clear_q();
    m_awready = 1'b0;
    fork
      mwrite(0, 32'h200, 1, 32'hB0, 4'h4, 0);
      begin : bp_slave
        step();
        repeat (5) begin
          @(negedge clk);
          chk("bp_awvalid", m_awvalid, 1);
          chk("bp_awaddr", m_awaddr, 32'h200);
          chk("bp_s_awready", s_awready, 0);
          step();
        end
        m_awready = 1'b1;
        step();
        for (int j = 0; j < 8; j++) begin
          m_wready = (j % 2 == 1);
          step();
        end
        m_wready = 1'b1;
      end
    join
    chk("bp_beats", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("bp_beat0", wq[0], 32'hB0);
      chk("bp_beat1", wq[1], 32'hB1);
    end
    step();

    // Early W: W valid 3 cycles ahead of AW.
    clear_q();
    mwrite(0, 32'h300, 0, 32'hE0, 4'h6, 3);
    chk("early_beats", wq.size(), 1);
    if (wq.size() > 0) chk("early_data", wq[0], 32'hE0);
    step();

    // Error response with ID.
    clear_q();
    bresp_cfg = 2'b10; bid_cfg = 4'h5;
    mwrite(1, 32'h400, 0, 32'hF0, 4'h5, 0);
    chk("err_bcount", bv_q.size(), 1);
    if (bv_q.size() > 0) begin
      chk("err_bvalid", bv_q[0], 2'b10);
      chk("err_bresp", br_q[0], 2'b10);
      chk("err_bid", bid_q[0], 4'h5);
    end
    bresp_cfg = 2'b00; bid_cfg = 4'h0;
    step();

    // Reset after beat 2 of a 4-beat burst.
    clear_q();
    fork
      mwrite(0, 32'h500, 3, 32'h50, 4'h7, 0);
      begin : rst_drv
        int n;
        n = 0;
        do begin step(); n++; end while (wq.size() < 2 && n < 100);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
      end
    join
    @(negedge clk);
    chk("mrst_grant", grant, 0);
    chk("mrst_valids", {m_awvalid, m_wvalid, m_bready}, 0);
    chk("mrst_s_ready", {s_awready, s_wready, s_bvalid}, 0);
    step();
    clear_q();
    mwrite(1, 32'h600, 0, 32'h60, 4'h8, 0);
    chk("mrst_next_count", aw_own.size(), 1);
    if (aw_own.size() > 0) chk("mrst_next_owner", aw_own[0], 1);
    if (wq.size() > 0) chk("mrst_next_data", wq[0], 32'h60);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
